// File: rtl/reward_spawner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : reward_spawner
// Brief    : Places a random reward (type 1..3) on a free interior grid cell.
//            A free-running 16-bit LFSR supplies the candidates. A small FSM
//            spaces offers apart by a 4 Hz tick count, withdraws an offer on
//            collection or timeout, and parks in IDLE while the game is
//            disabled.
// Revision : 1.0 - initial release
// ============================================================================
module reward_spawner #(
    parameter int          GRID_W        = 40,
    parameter int          GRID_H        = 30,
    parameter int          SPAWN_DELAY   = 20,
    parameter int          OFFER_TIMEOUT = 40,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_4Hz,
    input  logic        enable,
    input  logic        set_finish,
    output logic        set_require,
    output logic [1:0]  reward_type,
    output logic [5:0]  random_xpos,
    output logic [5:0]  random_ypos,
    output logic [15:0] dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GEN   = 2'd2,
        ST_OFFER = 2'd3
    } state_t;

    // The counter holds the number of ticks already seen, so the N-th tick
    // arrives while the counter equals N-1.
    localparam logic [7:0] C_DELAY_LAST   = 8'(SPAWN_DELAY - 1);
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(OFFER_TIMEOUT - 1);
    localparam logic [5:0] C_X_MAX        = 6'(GRID_W - 2);
    localparam logic [5:0] C_Y_MAX        = 6'(GRID_H - 2);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [15:0] lfsr_q,  lfsr_d;
    logic        req_q,   req_d;
    logic [1:0]  type_q,  type_d;
    logic [5:0]  x_q,     x_d;
    logic [5:0]  y_q,     y_d;

    logic [5:0]  w_cand_x;
    logic [5:0]  w_cand_y;
    logic [1:0]  w_cand_type;
    logic        w_cand_ok;
    logic [7:0]  w_cnt_inc;

    // Candidate fields and their legality (border cells and type 0 rejected).
    always_comb begin
        w_cand_x    = lfsr_q[5:0];
        w_cand_y    = lfsr_q[11:6];
        w_cand_type = lfsr_q[13:12];
        w_cand_ok   = (w_cand_x >= 6'd1) && (w_cand_x <= C_X_MAX) &&
                      (w_cand_y >= 6'd1) && (w_cand_y <= C_Y_MAX) &&
                      (w_cand_type != 2'd0);
        w_cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    // Fibonacci LFSR, taps 16,14,13,11; shifts every cycle unconditionally.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Next-state and offer register logic; enable=0 overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        type_d  = type_q;
        x_d     = x_q;
        y_d     = y_q;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                end
                ST_WAIT: begin
                    if (tick_4Hz) begin
                        if (cnt_q >= C_DELAY_LAST) begin
                            state_d = ST_GEN;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end
                end
                ST_GEN: begin
                    // A still-high collect strobe blocks the new offer so a
                    // stuck consumer cannot instantly swallow it.
                    if (w_cand_ok && !set_finish) begin
                        x_d     = w_cand_x;
                        y_d     = w_cand_y;
                        type_d  = w_cand_type;
                        req_d   = 1'b1;
                        state_d = ST_OFFER;
                        cnt_d   = 8'd0;
                    end
                end
                ST_OFFER: begin
                    // Collection wins over a coincident timeout tick; both
                    // lead to the same place anyway.
                    if (set_finish) begin
                        req_d   = 1'b0;
                        state_d = ST_WAIT;
                        cnt_d   = 8'd0;
                    end else if (tick_4Hz) begin
                        if (cnt_q >= C_TIMEOUT_LAST) begin
                            req_d   = 1'b0;
                            state_d = ST_WAIT;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // State, counter, LFSR and offer registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            lfsr_q  <= LFSR_SEED;
            req_q   <= 1'b0;
            type_q  <= 2'd0;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            req_q   <= req_d;
            type_q  <= type_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign set_require = req_q;
    assign reward_type = type_q;
    assign random_xpos = x_q;
    assign random_ypos = y_q;
    assign dout        = lfsr_q;

endmodule
`default_nettype wire
